rally_ctrl: RTL and testbench
=============================

// Module: rally_ctrl
// PURPOSE
//  Round sequencer for the PikaBall game. Holds ball, NPC and player in reset between rallies,
//  releases them for play, detects ball touchdown, awards points, picks next server, ends game.
//  Sits between top-level button input and ball/npc/player motion blocks; drives their reset/enable.
// PARAMETERS
//  VBUF_H      240        virtual frame height (px)
//  NET_POS     160        net x coordinate (px); ball centre >= NET_POS is NPC half
//  BALL_W      32         ball sprite width (px)
//  GROUND_Y    220        floor y (px); touchdown when ball_y + BALL_H >= GROUND_Y
//  BALL_H      32         ball sprite height (px)
//  SERVE_CYC   50_000_000 cycles held in SERVE before play starts
//  POINT_CYC   100_000_000 cycles held in POINT (celebration) before next serve
//  WIN_SCORE   15         score that ends the game (max 15, 4-bit scores)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   synchronous active-low reset
//  btn_start    in   1   raw asynchronous start button, active-high
//  ball_pos_x   in   12  ball top-left x (px)
//  ball_pos_y   in   12  ball top-left y (px)
//  obj_rst_n    out  1   active-low reset to ball/npc/player (places them at serve spots)
//  play_en      out  1   1 = motion blocks may update
//  serve_side   out  1   0 = player serves, 1 = NPC serves (valid while obj_rst_n low)
//  score_player out  4   player score
//  score_npc    out  4   NPC score
//  game_over    out  1   1 while in GAMEOVER
//  state        out  3   current state encoding (debug/LED)
// BEHAVIOUR
//  - Reset: state=IDLE(0), obj_rst_n=0, play_en=0, serve_side=0, scores=0, game_over=0, timer=0,
//    synchroniser and edge regs cleared. Reset mid-rally aborts immediately, no point awarded.
//  - btn_start: 2-FF synchroniser + rising-edge detect -> start_pulse, 1 cycle, 3-cycle latency
//    from button edge. Held button yields exactly one pulse.
//  - Ball position registered once (1-cycle latency). touchdown = reg_y + BALL_H >= GROUND_Y,
//    computed in 13 bits (no wrap). side_npc = reg_x + BALL_W/2 >= NET_POS, 13 bits.
//  - States (3-bit): IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4; others -> IDLE next cycle.
//    IDLE:     obj_rst_n=0, play_en=0. start_pulse -> scores cleared, serve_side=0, timer=0, SERVE.
//    SERVE:    obj_rst_n=0, play_en=0. timer counts up; at timer==SERVE_CYC-1 -> PLAY, timer=0.
//    PLAY:     obj_rst_n=1, play_en=1. Touchdown is ignored on first 2 cycles of PLAY (register
//              pipeline still holds serve-spot values). Touchdown -> POINT in next cycle:
//              side_npc=1 -> score_player+1, serve_side<=0; else score_npc+1, serve_side<=1.
//    POINT:    obj_rst_n=1, play_en=0 (frozen frame). At timer==POINT_CYC-1: if either score
//              ==WIN_SCORE -> GAMEOVER, else -> SERVE; timer=0.
//    GAMEOVER: obj_rst_n=0, play_en=0, game_over=1. start_pulse -> IDLE path: scores cleared,
//              serve_side=0, go SERVE directly.
//  - Score increment at most once per rally (only on PLAY->POINT transition); scores saturate at
//    WIN_SCORE, never wrap. start_pulse in SERVE/PLAY/POINT ignored.
//  - All outputs registered; output changes appear the cycle after the state transition.
//  - Timer 32-bit, cleared on every state entry.
// TESTING (bench uses SERVE_CYC=10, POINT_CYC=20, WIN_SCORE=3)
//  1 reset_n=0 2 cycles -> state=0, obj_rst_n=0, play_en=0, scores 0/0, game_over=0.
//  2 btn_start held 50 cycles in IDLE -> one start_pulse; SERVE for 10 cycles, then PLAY, play_en=1.
//  3 PLAY, ball (200,200) -> POINT, score_player=1, serve_side=0, play_en=0; after 20 cyc SERVE.
//  4 PLAY, ball (40,200) held 30 cycles -> score_npc=1 only (no double count), serve_side=1.
//  5 NPC wins 3 rallies -> GAMEOVER, game_over=1, score_npc=3; start -> scores 0/0, SERVE.
//  6 reset_n=0 mid-PLAY -> next cycle IDLE, scores 0, obj_rst_n=0; btn press in PLAY ignored.

Source files
------------

// File: rtl/rally_ctrl.sv
// rally_ctrl: round sequencer for PikaBall.
// Holds ball/NPC/player in reset between rallies, releases them for play,
// detects touchdown, awards the point, picks the next server, and ends the
// game once a side reaches WIN_SCORE. Reset is synchronous and active-low.
module rally_ctrl #(
  parameter int VBUF_H    = 240,
  parameter int NET_POS   = 160,
  parameter int BALL_W    = 32,
  parameter int GROUND_Y  = 220,
  parameter int BALL_H    = 32,
  parameter int SERVE_CYC = 50_000_000,
  parameter int POINT_CYC = 100_000_000,
  parameter int WIN_SCORE = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic [11:0] ball_pos_x,
  input  logic [11:0] ball_pos_y,
  output logic        obj_rst_n,
  output logic        play_en,
  output logic        serve_side,
  output logic [3:0]  score_player,
  output logic [3:0]  score_npc,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam logic [31:0] SERVE_LAST = 32'(SERVE_CYC - 1);
  localparam logic [31:0] POINT_LAST = 32'(POINT_CYC - 1);
  localparam logic [3:0]  WIN4       = 4'(WIN_SCORE);
  localparam logic [12:0] BALL_H13   = 13'(BALL_H);
  localparam logic [12:0] HALF_W13   = 13'(BALL_W / 2);
  localparam logic [12:0] GROUND13   = 13'(GROUND_Y);
  localparam logic [12:0] NET13      = 13'(NET_POS);
  localparam logic [11:0] VBUF12     = 12'(VBUF_H);

  // Start button synchroniser and edge detector
  logic btn_meta, btn_sync, btn_prev, start_pulse;

  // Registered ball position and the decisions derived from it
  logic [11:0] reg_x, reg_y;
  logic        touchdown, side_npc;

  // FSM state, dwell timer and scoring controls
  state_t      state_q, state_d;
  logic [31:0] timer_q;
  logic        clear_scores, award_player, award_npc;

  // Unregistered versions of the control outputs
  logic obj_rst_n_d, play_en_d, game_over_d;

  // Two-flop synchroniser, then a registered rising-edge pulse (3 cycles after the press)
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      btn_prev    <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      btn_meta    <= btn_start;
      btn_sync    <= btn_meta;
      btn_prev    <= btn_sync;
      start_pulse <= btn_sync & ~btn_prev;
    end
  end

  // Capture ball position once so touchdown/side logic sees a stable value
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_x <= '0;
      reg_y <= '0;
    end else begin
      reg_x <= ball_pos_x;
      reg_y <= ball_pos_y;
    end
  end

  // 13-bit sums so a ball near the 12-bit limit cannot wrap back above the floor.
  // A ball below the visible frame always counts as landed, even if GROUND_Y is retuned.
  assign touchdown = (({1'b0, reg_y} + BALL_H13) >= GROUND13) || (reg_y >= VBUF12);
  assign side_npc  = ({1'b0, reg_x} + HALF_W13) >= NET13;

  // State register plus the registers that change on transitions (timer, scores, server)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      score_player <= '0;
      score_npc    <= '0;
      serve_side   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (state_q == S_SERVE || state_q == S_PLAY || state_q == S_POINT) begin
        // Saturate so a very long rally cannot wrap back into the touchdown guard window
        timer_q <= timer_q + {31'd0, (timer_q != '1)};
      end else begin
        timer_q <= '0;
      end

      if (clear_scores) begin
        score_player <= '0;
        score_npc    <= '0;
        serve_side   <= 1'b0;
      end else if (award_player) begin
        if (score_player < WIN4) score_player <= score_player + 4'd1;
        serve_side <= 1'b0;
      end else if (award_npc) begin
        if (score_npc < WIN4) score_npc <= score_npc + 4'd1;
        serve_side <= 1'b1;
      end
    end
  end

  // Next-state decision and the one-cycle scoring strobes
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d      = state_q;
    clear_scores = 1'b0;
    award_player = 1'b0;
    award_npc    = 1'b0;
    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (start_pulse) begin
          clear_scores = 1'b1;
          state_d      = S_SERVE;
        end
      end
      S_SERVE: begin
        if (timer_q == SERVE_LAST) state_d = S_PLAY;
      end
      S_PLAY: begin
        // First two PLAY cycles still see serve-spot positions in the register pipeline
        if (timer_q >= 32'd2 && touchdown) begin
          state_d = S_POINT;
          if (side_npc) award_player = 1'b1;
          else          award_npc    = 1'b1;
        end
      end
      S_POINT: begin
        if (timer_q == POINT_LAST) begin
          if (score_player == WIN4 || score_npc == WIN4) state_d = S_GAMEOVER;
          else                                           state_d = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control levels implied by the current state
  always_comb begin
    obj_rst_n_d = 1'b0;
    play_en_d   = 1'b0;
    game_over_d = 1'b0;
    case (state_q)
      S_PLAY: begin
        obj_rst_n_d = 1'b1;
        play_en_d   = 1'b1;
      end
      S_POINT:    obj_rst_n_d = 1'b1;
      S_GAMEOVER: game_over_d = 1'b1;
      default: ;
    endcase
  end

  // Register the control outputs so downstream blocks see glitch-free levels
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      obj_rst_n <= 1'b0;
      play_en   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      obj_rst_n <= obj_rst_n_d;
      play_en   <= play_en_d;
      game_over <= game_over_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// tb_rally_ctrl: scoreboard bench for rally_ctrl with short timers
// (SERVE_CYC=10, POINT_CYC=20, WIN_SCORE=3). Stimulus pushes the expected
// record for each state change; the monitor pops and compares on each change.
module tb_rally_ctrl;

  localparam int SERVE_CYC = 10;
  localparam int POINT_CYC = 20;
  localparam int WIN_SCORE = 3;

  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_POINT = 3, ST_GAMEOVER = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start;
  logic [11:0] ball_pos_x, ball_pos_y;
  logic        obj_rst_n, play_en, serve_side, game_over;
  logic [3:0]  score_player, score_npc;
  logic [2:0]  state;

  rally_ctrl #(
    .SERVE_CYC(SERVE_CYC),
    .POINT_CYC(POINT_CYC),
    .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_start(btn_start),
    .ball_pos_x(ball_pos_x),
    .ball_pos_y(ball_pos_y),
    .obj_rst_n(obj_rst_n),
    .play_en(play_en),
    .serve_side(serve_side),
    .score_player(score_player),
    .score_npc(score_npc),
    .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int sp;
    int sn;
    int ss;
    int go;
    int obj;
    int pen;
    int dwell;  // cycles spent in the previous state, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Bench-side game model
  int   m_sp = 0, m_sn = 0, m_ss = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int st, input int go, input int obj, input int pen, input int dwell);
    exp_t e;
    e.st = st; e.sp = m_sp; e.sn = m_sn; e.ss = m_ss;
    e.go = go; e.obj = obj; e.pen = pen; e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input int st, input string name);
    int n = 0;
    while (int'(state) != st && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (int'(state) != st) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for state %0d, state is %0d", name, st, int'(state));
    end
  endtask

  task automatic press(input int cycles);
    btn_start = 1'b1;
    repeat (cycles) @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic set_ball(input int x, input int y);
    ball_pos_x = 12'(x);
    ball_pos_y = 12'(y);
  endtask

  // One rally: the ball lands at (x,y); hold>0 keeps it there for that many cycles
  task automatic rally(input int x, input int y, input int hold, input string name);
    bit npc_pt;
    wait_state(ST_PLAY, name);
    npc_pt = (x + 16 >= 160) ? 1'b0 : 1'b1;  // centre in NPC half -> player scores
    if (npc_pt) begin m_sn++; m_ss = 1; end
    else        begin m_sp++; m_ss = 0; end
    push(ST_POINT, 0, 1, 0, -1);
    if (m_sp == WIN_SCORE || m_sn == WIN_SCORE) begin
      push(ST_GAMEOVER, 1, 0, 0, POINT_CYC);
    end else begin
      push(ST_SERVE, 0, 0, 0, POINT_CYC);
      push(ST_PLAY, 0, 1, 1, SERVE_CYC);
    end
    set_ball(x, y);
    if (hold > 0) repeat (hold) @(negedge clk);
    else          wait_state(ST_POINT, name);
    set_ball(40, 100);
  endtask

  // Monitor: on every state change, compare the settled outputs one cycle later
  initial begin
    int   cyc = 0, last_change = 0, prev = 0, dwell_seen = 0;
    bit   pending = 1'b0;
    exp_t e;
    wait (mon_en);
    prev = int'(state);
    forever begin
      @(negedge clk);
      cyc++;
      if (pending) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition: state now %0d with no expected record", int'(state));
        end else begin
          e = exp_q.pop_front();
          check("state", int'(state), e.st);
          check("score_player", int'(score_player), e.sp);
          check("score_npc", int'(score_npc), e.sn);
          check("serve_side", int'(serve_side), e.ss);
          check("game_over", int'(game_over), e.go);
          check("obj_rst_n", int'(obj_rst_n), e.obj);
          check("play_en", int'(play_en), e.pen);
          if (e.dwell >= 0) check("dwell", dwell_seen, e.dwell);
        end
      end
      if (int'(state) != prev) begin
        pending     = 1'b1;
        dwell_seen  = cyc - last_change;
        last_change = cyc;
        prev        = int'(state);
      end
    end
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    btn_start = 1'b0;
    set_ball(40, 100);

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), ST_IDLE);
    check("rst_obj_rst_n", int'(obj_rst_n), 0);
    check("rst_play_en", int'(play_en), 0);
    check("rst_scores", int'({score_player, score_npc}), 0);
    check("rst_game_over", int'(game_over), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(negedge clk);

    // 2: held button gives one start; SERVE lasts SERVE_CYC, then PLAY
    push(ST_SERVE, 0, 0, 0, -1);
    push(ST_PLAY, 0, 1, 1, SERVE_CYC);
    press(50);

    // 3: ball in NPC half -> player point, player serves next
    rally(200, 200, 0, "rally_player");

    // 4: ball in player half held 30 cycles -> exactly one NPC point
    rally(40, 200, 30, "rally_npc_hold");

    // 5: NPC takes two more rallies and wins; start restarts with cleared scores
    rally(40, 210, 0, "rally_npc2");
    rally(10, 300, 0, "rally_npc3");
    wait_state(ST_GAMEOVER, "gameover");
    repeat (2) @(negedge clk);
    m_sp = 0; m_sn = 0; m_ss = 0;
    push(ST_SERVE, 0, 0, 0, -1);
    push(ST_PLAY, 0, 1, 1, SERVE_CYC);
    press(4);

    // 6: player point, then button in PLAY ignored, then reset mid-PLAY
    rally(300, 250, 0, "rally_player2");
    wait_state(ST_PLAY, "play_before_reset");
    press(6);
    repeat (6) @(negedge clk);
    check("btn_in_play_ignored", int'(state), ST_PLAY);
    check("score_before_reset", int'(score_player), 1);
    m_sp = 0; m_sn = 0; m_ss = 0;
    push(ST_IDLE, 0, 0, 0, -1);
    reset_n = 1'b0;
    @(negedge clk);
    check("reset_mid_play_state", int'(state), ST_IDLE);
    check("reset_mid_play_score", int'(score_player), 0);
    check("reset_mid_play_obj", int'(obj_rst_n), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", int'(state), ST_IDLE);

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
